// File: rtl/pipe_addsub_seg.sv
// rtl/pipe_addsub_seg.sv - segmented pipelined add/sub with carry/borrow-in and valid/ready streaming.
// One register stage per SEG_W-bit carry segment; the whole pipe stalls together when the output is blocked.
module pipe_addsub_seg #(
  parameter int WIDTH = 16,
  parameter int SEG_W = 4
) (
  input  logic             CLK_in,
  input  logic             RST_in,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  input  logic             Cin_in,
  input  logic             Sub_in,
  input  logic             Valid_in,
  output logic             Ready_out,
  output logic [WIDTH:0]   Sum_out,
  output logic             Ovf_out,
  output logic             Valid_out,
  input  logic             Ready_in
);

  localparam int NSEG = WIDTH / SEG_W;
  localparam int LAST = NSEG - 1;

  generate
    if (WIDTH % SEG_W != 0) begin : g_width_check
      $error("pipe_addsub_seg: WIDTH must be an integer multiple of SEG_W");
    end
  endgenerate

  // Per-stage state: operand skew copies, partial result, segment carry-out, valid.
  logic [WIDTH-1:0] a_q [NSEG];
  logic [WIDTH-1:0] b_q [NSEG];
  logic [WIDTH-1:0] r_q [NSEG];
  logic             c_q [NSEG];
  logic             v_q [NSEG];

  logic [SEG_W:0]   seg_sum [NSEG];
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic             en;
  logic             take;

  // Subtraction is folded in at the input so later stages only ever add.
  assign b_eff   = Sub_in ? ~B_in : B_in;
  assign cin_eff = Sub_in ? ~Cin_in : Cin_in;

  assign en        = Ready_in || !v_q[LAST];
  assign Ready_out = en;
  assign take      = Valid_in && en;

  always_comb begin
    for (int k = 0; k < NSEG; k++) begin
      seg_sum[k] = '0;
    end
    seg_sum[0] = {1'b0, A_in[SEG_W-1:0]} + {1'b0, b_eff[SEG_W-1:0]}
               + (SEG_W+1)'(cin_eff);
    for (int k = 1; k < NSEG; k++) begin
      seg_sum[k] = {1'b0, a_q[k-1][k*SEG_W +: SEG_W]}
                 + {1'b0, b_q[k-1][k*SEG_W +: SEG_W]}
                 + (SEG_W+1)'(c_q[k-1]);
    end
  end

  // Data registers load only behind a valid beat, so the output holds its last result across bubbles.
  always_ff @(posedge CLK_in) begin
    if (RST_in) begin
      for (int k = 0; k < NSEG; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
      end
    end else if (en) begin
      v_q[0] <= take;
      if (take) begin
        a_q[0] <= A_in;
        b_q[0] <= b_eff;
        r_q[0] <= WIDTH'(seg_sum[0][SEG_W-1:0]);
        c_q[0] <= seg_sum[0][SEG_W];
      end
      for (int k = 1; k < NSEG; k++) begin
        v_q[k] <= v_q[k-1];
        if (v_q[k-1]) begin
          a_q[k] <= a_q[k-1];
          b_q[k] <= b_q[k-1];
          c_q[k] <= seg_sum[k][SEG_W];
          r_q[k] <= r_q[k-1];
          r_q[k][k*SEG_W +: SEG_W] <= seg_sum[k][SEG_W-1:0];
        end
      end
    end
  end

  assign Valid_out = v_q[LAST];
  assign Sum_out   = {c_q[LAST], r_q[LAST]};
  assign Ovf_out   = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1])
                  && (r_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

endmodule

// File: tb/tb_pipe_addsub_seg.sv
// tb/tb_pipe_addsub_seg.sv - directed vector bench for pipe_addsub_seg (WIDTH=16, SEG_W=4).
module tb_pipe_addsub_seg;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        valid_in;
  logic        ready_out;
  logic [16:0] sum_out;
  logic        ovf_out;
  logic        valid_out;
  logic        ready_in;

  int checks = 0;
  int errors = 0;
  logic [16:0] got [$];

  always #5 clk = ~clk;

  pipe_addsub_seg #(.WIDTH(16), .SEG_W(4)) dut (
    .CLK_in   (clk),
    .RST_in   (rst),
    .A_in     (a),
    .B_in     (b),
    .Cin_in   (cin),
    .Sub_in   (sub),
    .Valid_in (valid_in),
    .Ready_out(ready_out),
    .Sum_out  (sum_out),
    .Ovf_out  (ovf_out),
    .Valid_out(valid_out),
    .Ready_in (ready_in)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [16:0] sum;
    logic        ovf;
  } vec_t;

  vec_t vecs [10];

  always @(negedge clk) begin
    if (!rst && valid_out && ready_in) got.push_back(sum_out);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [15:0] va, input logic [15:0] vb,
                           input logic vc, input logic vs);
    logic acc;
    int   n;
    a = va; b = vb; cin = vc; sub = vs; valid_in = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = ready_out;
      step();
      n++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    valid_in = 1'b0;
  endtask

  initial begin
    logic [16:0] held;
    int          n;
    int          stale;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 1'b0};
    vecs[1] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0FFFE, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 17'h17FFF, 1'b1};
    vecs[3] = '{16'h7FFF, 16'h0001, 1'b1, 1'b0, 17'h08001, 1'b1};
    vecs[4] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 17'h05555, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 17'h0FFFF, 1'b0};
    vecs[6] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 17'h10000, 1'b0};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 17'h10000, 1'b1};
    vecs[8] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 17'h08000, 1'b1};
    vecs[9] = '{16'h0FFF, 16'h0001, 1'b1, 1'b0, 17'h01001, 1'b0};

    rst = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    valid_in = 1'b0; ready_in = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("reset_valid_out", {31'd0, valid_out}, 32'd0);
    chk("reset_sum_out", {15'd0, sum_out}, 32'd0);
    chk("reset_ovf_out", {31'd0, ovf_out}, 32'd0);
    chk("reset_ready_out", {31'd0, ready_out}, 32'd1);

    // Single beats: result appears exactly 4 cycles after acceptance, for one cycle.
    for (int i = 0; i < 10; i++) begin
      a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; sub = vecs[i].sub;
      valid_in = 1'b1;
      step();
      valid_in = 1'b0;
      step();
      step();
      chk($sformatf("vec%0d_early_valid", i), {31'd0, valid_out}, 32'd0);
      step();
      chk($sformatf("vec%0d_valid", i), {31'd0, valid_out}, 32'd1);
      chk($sformatf("vec%0d_sum", i), {15'd0, sum_out}, {15'd0, vecs[i].sum});
      chk($sformatf("vec%0d_ovf", i), {31'd0, ovf_out}, {31'd0, vecs[i].ovf});
      step();
      chk($sformatf("vec%0d_one_cycle", i), {31'd0, valid_out}, 32'd0);
      chk($sformatf("vec%0d_sum_hold", i), {15'd0, sum_out}, {15'd0, vecs[i].sum});
    end

    // Back-to-back stream: four results on consecutive cycles.
    for (int i = 1; i <= 4; i++) begin
      a = 16'(i); b = 16'(i); cin = 1'b0; sub = 1'b0; valid_in = 1'b1;
      step();
    end
    valid_in = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("stream%0d_valid", i), {31'd0, valid_out}, 32'd1);
      chk($sformatf("stream%0d_sum", i), {15'd0, sum_out}, 32'(2 * i));
      step();
    end
    chk("stream_end_valid", {31'd0, valid_out}, 32'd0);

    // Output stall for 3 cycles with a stream in flight.
    got.delete();
    fork
      begin
        for (int i = 0; i < 6; i++) send_beat(16'(i * 16'h0111), 16'h0001, 1'b0, 1'b0);
      end
      begin
        n = 0;
        while (!valid_out && n < 20) begin
          step();
          n++;
        end
        chk("stall_reached_output", {31'd0, valid_out}, 32'd1);
        held = sum_out;
        ready_in = 1'b0;
        for (int c = 0; c < 3; c++) begin
          step();
          chk($sformatf("stall%0d_ready_out", c), {31'd0, ready_out}, 32'd0);
          chk($sformatf("stall%0d_valid_out", c), {31'd0, valid_out}, 32'd1);
          chk($sformatf("stall%0d_sum_out", c), {15'd0, sum_out}, {15'd0, held});
        end
        ready_in = 1'b1;
      end
    join
    n = 0;
    while (got.size() < 6 && n < 30) begin
      step();
      n++;
    end
    chk("stall_count", got.size(), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < got.size())
        chk($sformatf("stall_order%0d", i), {15'd0, got[i]}, 32'(i * 32'h111 + 1));
    end

    // Reset with three beats in flight.
    step();
    for (int i = 0; i < 3; i++) begin
      a = 16'h0100; b = 16'(i); cin = 1'b0; sub = 1'b0; valid_in = 1'b1;
      step();
    end
    valid_in = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_valid_out", {31'd0, valid_out}, 32'd0);
    chk("midrst_sum_out", {15'd0, sum_out}, 32'd0);
    chk("midrst_ready_out", {31'd0, ready_out}, 32'd1);
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (valid_out) stale++;
    end
    chk("midrst_no_stale", stale, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
